mac_vector_requant: RTL and testbench

//   N_LANES-wide multiply-accumulate engine for the convolution datapath: each lane

---
 rtl/mac_vector_requant.sv | 146 ++++++++++++++
 tb/tb_mac_vector_requant.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_vector_requant.sv
// N_LANES-wide multiply-accumulate over a programmable vector length, with
// round-half-up requantization, saturation and a one-entry output register.
module mac_vector_requant #(
  parameter int N_LANES   = 4,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter bit A_SIGNED  = 1'b0,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8,
  parameter int K_MAX     = 1024
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic [$clog2(K_MAX+1)-1:0]     cfg_k_len,
  input  logic [$clog2(ACC_WIDTH)-1:0]   cfg_shift,
  input  logic                           clear_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_LANES*A_WIDTH-1:0]     in_a,
  input  logic [N_LANES*B_WIDTH-1:0]     in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_LANES*OUT_WIDTH-1:0]   out_data,
  output logic [N_LANES-1:0]             out_sat,
  output logic                           busy
);

  localparam int K_W   = $clog2(K_MAX + 1);
  localparam int CNT_W = $clog2(K_MAX);
  localparam int SH_W  = $clog2(ACC_WIDTH);
  localparam int PW    = A_WIDTH + B_WIDTH + 1;

  localparam logic [K_W-1:0] K_MAX_W = K_W'(K_MAX);
  localparam logic signed [ACC_WIDTH:0] OMAX =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OMIN =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [CNT_W-1:0]                cnt_q;
  logic [K_W-1:0]                  k_len_q;
  logic [SH_W-1:0]                 shift_q;
  logic signed [ACC_WIDTH-1:0]     acc_q [N_LANES];
  logic                            out_valid_q;
  logic [N_LANES*OUT_WIDTH-1:0]    out_data_q;
  logic [N_LANES-1:0]              out_sat_q;

  logic                            first;
  logic                            last;
  logic                            accept;
  logic [K_W-1:0]                  k_cfg_eff;
  logic [K_W-1:0]                  k_cur;
  logic [SH_W-1:0]                 s_cur;
  logic signed [PW-1:0]            a_ext;
  logic signed [PW-1:0]            b_ext;
  logic signed [PW-1:0]            prod;
  logic signed [ACC_WIDTH-1:0]     acc_d [N_LANES];
  logic [N_LANES*OUT_WIDTH-1:0]    out_data_d;
  logic [N_LANES-1:0]              out_sat_d;
  logic [OUT_WIDTH:0]              rq;

  // Returns {saturated, value}; the extra bit keeps the rounding add from wrapping.
  function automatic logic [OUT_WIDTH:0] requant(input logic signed [ACC_WIDTH-1:0] x,
                                                 input logic [SH_W-1:0] s);
    logic signed [ACC_WIDTH:0] t;
    logic signed [ACC_WIDTH:0] rnd;
    t   = (ACC_WIDTH+1)'(x);
    rnd = '0;
    if (s != '0) begin
      rnd[s - 1'b1] = 1'b1;
      t = (t + rnd) >>> s;
    end
    if (t > OMAX)      return {1'b1, OMAX[OUT_WIDTH-1:0]};
    else if (t < OMIN) return {1'b1, OMIN[OUT_WIDTH-1:0]};
    else               return {1'b0, t[OUT_WIDTH-1:0]};
  endfunction

  assign in_ready = !clear_in && !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (cnt_q != '0);

  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    out_data_d = '0;
    out_sat_d  = '0;
    a_ext      = '0;
    b_ext      = '0;
    prod       = '0;
    rq         = '0;
    first      = (cnt_q == '0);
    if (cfg_k_len == '0)         k_cfg_eff = K_W'(1);
    else if (cfg_k_len > K_MAX_W) k_cfg_eff = K_MAX_W;
    else                          k_cfg_eff = cfg_k_len;
    // Config takes effect on the first beat itself, then the latched copy rules.
    k_cur = first ? k_cfg_eff : k_len_q;
    s_cur = first ? cfg_shift : shift_q;
    last  = (K_W'(cnt_q) == k_cur - 1'b1);
    for (int i = 0; i < N_LANES; i++) begin
      a_ext = A_SIGNED ? PW'($signed(in_a[i*A_WIDTH +: A_WIDTH]))
                       : PW'($signed({1'b0, in_a[i*A_WIDTH +: A_WIDTH]}));
      b_ext = PW'($signed(in_b[i*B_WIDTH +: B_WIDTH]));
      prod  = a_ext * b_ext;
      acc_d[i] = first ? ACC_WIDTH'(prod) : acc_q[i] + ACC_WIDTH'(prod);
      rq = requant(acc_d[i], s_cur);
      out_sat_d[i] = rq[OUT_WIDTH];
      out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = rq[OUT_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      cnt_q       <= '0;
      k_len_q     <= K_W'(1);
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      // NOTE: the accumulators are a handful of flops, not a RAM, so resetting them costs nothing.
      for (int i = 0; i < N_LANES; i++) acc_q[i] <= '0;
    end else begin
      if (clear_in) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (first) begin
          k_len_q <= k_cfg_eff;
          shift_q <= cfg_shift;
        end
        for (int i = 0; i < N_LANES; i++) acc_q[i] <= acc_d[i];
      end
      // A finishing vector may replace a result that is popped in the same cycle.
      if (accept && last) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_sat_q   <= out_sat_d;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_vector_requant.sv
// Self-checking bench for mac_vector_requant: directed vector table, multi-cycle
// corner sequences and a randomized run against a cycle-level reference model.
module tb_mac_vector_requant;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] cfg_k_len = '0;
  logic [4:0]  cfg_shift = '0;
  logic        clear_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_sat;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mac_vector_requant dut (
    .clk(clk), .rst_in(rst_in), .cfg_k_len(cfg_k_len), .cfg_shift(cfg_shift),
    .clear_in(clear_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d required=%0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_k(input int k);
    if (k == 0) return 1;
    if (k > 1024) return 1024;
    return k;
  endfunction

  function automatic void ref_rq(input int x, input int s, output int y, output bit sat);
    longint t;
    t = x;
    if (s > 0) t = (t + (longint'(1) << (s - 1))) >>> s;
    sat = 1'b0;
    if (t > 127) begin t = 127; sat = 1'b1; end
    else if (t < -128) begin t = -128; sat = 1'b1; end
    y = int'(t);
  endfunction

  bit       m_live = 1'b0;
  bit       m_ov = 1'b0;
  int       m_cnt = 0, m_k = 1, m_s = 0;
  int       m_sum [NL];
  int       m_od  [NL];
  bit [3:0] m_os = '0;
  int       popped [$];

  always @(negedge clk) begin
    bit exp_rdy, acc_b, pop, loaded, sat;
    int y;
    exp_rdy = !clear_in && !(m_ov && !out_ready);
    if (m_live) begin
      check("mon_in_ready", in_ready, exp_rdy);
      check("mon_out_valid", out_valid, m_ov);
      check("mon_busy", busy, m_cnt != 0);
      check("mon_out_sat", out_sat, m_os);
      for (int i = 0; i < NL; i++)
        check($sformatf("mon_out_data%0d", i), $signed(out_data[i*8 +: 8]), m_od[i]);
      if (out_valid && out_ready) popped.push_back(int'($signed(out_data[7:0])));
    end
    if (rst_in) begin
      m_live = 1'b1;
      m_ov = 1'b0; m_cnt = 0; m_os = '0;
      for (int i = 0; i < NL; i++) begin m_od[i] = 0; m_sum[i] = 0; end
    end else if (m_live) begin
      acc_b  = in_valid && exp_rdy;
      pop    = m_ov && out_ready;
      loaded = 1'b0;
      if (clear_in) m_cnt = 0;
      else if (acc_b) begin
        if (m_cnt == 0) begin
          m_k = eff_k(int'(cfg_k_len));
          m_s = int'(cfg_shift);
          for (int i = 0; i < NL; i++) m_sum[i] = 0;
        end
        for (int i = 0; i < NL; i++)
          m_sum[i] += int'({24'b0, in_a[i*8 +: 8]}) * int'($signed(in_b[i*8 +: 8]));
        m_cnt++;
        if (m_cnt == m_k) begin
          m_cnt = 0;
          for (int i = 0; i < NL; i++) begin
            ref_rq(m_sum[i], m_s, y, sat);
            m_od[i] = y;
            m_os[i] = sat;
          end
          m_ov = 1'b1;
          loaded = 1'b1;
        end
      end
      if (pop && !loaded) m_ov = 1'b0;
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct packed {
    int             k;
    int             sh;
    int             nbeats;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int             exp_y;
    logic           exp_sat;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [7:0] a0, input logic [7:0] b0);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = {24'b0, a0};
    in_b = {24'b0, b0};
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("send_beat_timeout", 0, 1);
  endtask

  task automatic wait_out(input string name, input int exp_y, input bit exp_sat, input bit chk_lat);
    bit got;
    got = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (c == 0 && chk_lat) check({name, "_latency"}, out_valid, 1);
      if (out_valid) begin
        check({name, "_y"}, $signed(out_data[7:0]), exp_y);
        check({name, "_sat"}, out_sat[0], exp_sat);
        got = 1'b1;
      end
      tick();
    end
    if (!got) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    cfg_k_len = 11'(v.k);
    cfg_shift = 5'(v.sh);
    out_ready = 1'b1;
    for (int j = 0; j < v.nbeats; j++) send_beat(v.a[j % 4], v.b[j % 4]);
    wait_out($sformatf("vec%0d", idx), v.exp_y, v.exp_sat, 1'b1);
  endtask

  task automatic pulse_rst();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    int idx;
    bit saw_block;

    vecs[0] = '{k:4,    sh:0, nbeats:4,    a:{8'd4, 8'd3, 8'd2, 8'd1}, b:{4{8'd2}},   exp_y:20,   exp_sat:1'b0};
    vecs[1] = '{k:1,    sh:0, nbeats:1,    a:{4{8'd127}},               b:{4{8'h80}},  exp_y:-128, exp_sat:1'b1};
    vecs[2] = '{k:2,    sh:2, nbeats:2,    a:{8'd0, 8'd0, 8'd2, 8'd3},  b:{4{8'd1}},   exp_y:1,    exp_sat:1'b0};
    vecs[3] = '{k:2,    sh:2, nbeats:2,    a:{4{8'd3}},                 b:{4{8'hFF}},  exp_y:-1,   exp_sat:1'b0};
    vecs[4] = '{k:1,    sh:8, nbeats:1,    a:{4{8'd255}},               b:{4{8'd127}}, exp_y:127,  exp_sat:1'b0};
    vecs[5] = '{k:1,    sh:0, nbeats:1,    a:{4{8'd255}},               b:{4{8'd127}}, exp_y:127,  exp_sat:1'b1};
    vecs[6] = '{k:0,    sh:0, nbeats:1,    a:{4{8'd5}},                 b:{4{8'd5}},   exp_y:25,   exp_sat:1'b0};
    vecs[7] = '{k:2000, sh:3, nbeats:1024, a:{4{8'd1}},                 b:{4{8'd1}},   exp_y:127,  exp_sat:1'b1};
    vecs[8] = '{k:3,    sh:1, nbeats:3,    a:{4{8'd1}},                 b:{4{8'hFF}},  exp_y:-1,   exp_sat:1'b0};
    vecs[9] = '{k:1,    sh:1, nbeats:1,    a:{4{8'd255}},               b:{4{8'h80}},  exp_y:-128, exp_sat:1'b1};

    repeat (3) tick();
    rst_in = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_sat", out_sat, 0);
    tick();

    for (int v = 0; v < 10; v++) run_vec(v, vecs[v]);

    // Stream of K=1 results with the consumer stalled for three cycles.
    cfg_k_len = 11'd1; cfg_shift = 5'd0;
    popped.delete();
    idx = 0; saw_block = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (idx < 8);
      in_a      = {24'b0, 8'(idx + 1)};
      in_b      = {24'b0, 8'd3};
      out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (out_valid && !out_ready && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_in_ready_dropped", saw_block, 1);
    check("stall_count", popped.size(), 8);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      check($sformatf("stall_order%0d", i), popped[i], 3 * (i + 1));

    // clear_in with a pending result, then abort a partial vector.
    out_ready = 1'b0;
    send_beat(8'd9, 8'd1);
    clear_in = 1'b1; tick(); clear_in = 1'b0;
    wait_out("clear_pending", 9, 1'b0, 1'b0);
    cfg_k_len = 11'd4; cfg_shift = 5'd0;
    send_beat(8'd7, 8'd7);
    send_beat(8'd7, 8'd7);
    in_valid = 1'b1; in_a = {24'b0, 8'd50}; in_b = {24'b0, 8'd50};
    clear_in = 1'b1; tick(); clear_in = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clear_busy", busy, 0);
    tick();
    for (int j = 0; j < 4; j++) send_beat(8'd1, 8'd1);
    wait_out("clear_restart", 4, 1'b0, 1'b1);

    // Reset with a result pending, then reset in the middle of a vector.
    out_ready = 1'b0; cfg_k_len = 11'd1;
    send_beat(8'd5, 8'd5);
    pulse_rst();
    @(negedge clk);
    check("rst_pending_valid", out_valid, 0);
    check("rst_pending_data", out_data, 0);
    tick();
    out_ready = 1'b1; cfg_k_len = 11'd3;
    send_beat(8'd2, 8'd2);
    send_beat(8'd2, 8'd2);
    pulse_rst();
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", out_valid, 0);
    tick();
    send_beat(8'd1, 8'd1);
    send_beat(8'd2, 8'd1);
    send_beat(8'd3, 8'd1);
    wait_out("rst_after", 6, 1'b0, 1'b1);

    // Randomized traffic: the negedge model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = $urandom();
      in_b      = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      clear_in  = ($urandom_range(0, 31) == 0);
      rst_in    = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 6) == 0) cfg_k_len = 11'($urandom_range(0, 6));
      if ($urandom_range(0, 6) == 0)
        cfg_shift = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 10));
      tick();
    end
    in_valid = 1'b0; clear_in = 1'b0; rst_in = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
